// File: rtl/uart_rx_fx.sv
// uart_rx_fx: parametrised UART receiver.
//   Configurable data bits (DBIT, LSB first), parity (PARITY: 0 none,
//   1 even, 2 odd) and stop length (SB_TICK ticks). The rx line goes
//   through a 2-flop synchroniser. Each bit is a 3-sample majority vote
//   taken around mid-cell. False starts are rejected, and parity, framing,
//   break and overrun conditions are flagged. One received word is held
//   under a valid/ack handshake.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   rx           serial line, asynchronous to clk, idle high
//   s_tick       one-clk oversample strobe at OVS x baud
//   rd_ack       consumer pulse: held word taken
//   rx_valid     dout/status hold an unread word
//   dout         received data
//   parity_err   parity mismatch on the held word
//   frame_err    stop bit sampled 0 on the held word
//   break_det    held word is a break
//   overrun      at least one frame dropped while rx_valid was set
//   rx_done_tick one-clk pulse per completed frame, accepted or dropped
module uart_rx_fx #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_ack,
  output logic            rx_valid,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun,
  output logic            rx_done_tick
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_V0   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVS / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_DONE = SW'(SB_TICK - OVS / 2 + 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [1:0]      v_q, v_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            perr_q, perr_d;
  logic            parv_q, parv_d;
  logic            stopv_q, stopv_d;
  logic            rx_valid_q, rx_valid_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            break_det_q, break_det_d;
  logic            overrun_q, overrun_d;

  logic rx_s, maj, stop_vote, brk_now, done;

  assign rx_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    v_d          = v_q;
    data_d       = data_q;
    perr_d       = perr_q;
    parv_d       = parv_q;
    stopv_d      = stopv_q;
    rx_valid_d   = rx_valid_q;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = overrun_q;
    done         = 1'b0;

    // Third vote is the live sample, so the decision is available on the
    // same tick as the last sample.
    maj = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
    // With a one-stop-bit length the stop vote and completion share a tick.
    stop_vote = (s_q == S_V2) ? maj : stopv_q;
    // parv_q is never written without parity, so it stays 0 there.
    brk_now = (data_q == '0) && !parv_q && !stop_vote;

    if (s_tick) begin
      if (s_q == S_V0) v_d[0] = rx_s;
      if (s_q == S_V1) v_d[1] = rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
          n_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_V2 && maj) begin
            state_d = ST_IDLE;
            s_d     = '0;
          end else if (s_q == S_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_V2) data_d = {maj, data_q[DBIT-1:1]};
          if (s_q == S_LAST) begin
            s_d = '0;
            if (n_q == N_LAST) state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_V2) begin
            parv_d = maj;
            perr_d = (^data_q) ^ maj ^ ODD;
          end
          if (s_q == S_LAST) begin
            state_d = ST_STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_V2) stopv_d = maj;
          if (s_q == S_DONE) begin
            done    = 1'b1;
            s_d     = '0;
            state_d = brk_now ? ST_BRK_WAIT : ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      if (!rx_valid_q || rd_ack) begin
        rx_valid_d   = 1'b1;
        dout_d       = data_q;
        parity_err_d = perr_q;
        frame_err_d  = ~stop_vote;
        break_det_d  = brk_now;
        if (rd_ack) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      s_q          <= '0;
      n_q          <= '0;
      v_q          <= '0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      parv_q       <= 1'b0;
      stopv_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      s_q          <= s_d;
      n_q          <= n_d;
      v_q          <= v_d;
      data_q       <= data_d;
      perr_q       <= perr_d;
      parv_q       <= parv_d;
      stopv_q      <= stopv_d;
      rx_valid_q   <= rx_valid_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_valid     = rx_valid_q;
  assign dout         = dout_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign break_det    = break_det_q;
  assign overrun      = overrun_q;
  assign rx_done_tick = done;

endmodule

// File: tb/tb_uart_rx_fx.sv
// tb_uart_rx_fx: scoreboard bench for uart_rx_fx.
//   Instance A: 8N1, OVS 16. Instance B: 7 data bits, even parity.
//   s_tick fires every 4 clk, so one bit cell is 64 clk.
module tb_uart_rx_fx;

  localparam int BT = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_a = 1'b1, rd_ack_a = 1'b0;
  logic       rx_b = 1'b1, rd_ack_b = 1'b0;

  logic       rx_valid_a, parity_err_a, frame_err_a, break_det_a, overrun_a, done_a;
  logic [7:0] dout_a;
  logic       rx_valid_b, parity_err_b, frame_err_b, break_det_b, overrun_b, done_b;
  logic [6:0] dout_b;

  uart_rx_fx #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(0)) u_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .s_tick(s_tick), .rd_ack(rd_ack_a),
    .rx_valid(rx_valid_a), .dout(dout_a), .parity_err(parity_err_a),
    .frame_err(frame_err_a), .break_det(break_det_a), .overrun(overrun_a),
    .rx_done_tick(done_a)
  );

  uart_rx_fx #(.DBIT(7), .OVS(16), .SB_TICK(16), .PARITY(1)) u_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .s_tick(s_tick), .rd_ack(rd_ack_b),
    .rx_valid(rx_valid_b), .dout(dout_b), .parity_err(parity_err_b),
    .frame_err(frame_err_b), .break_det(break_det_b), .overrun(overrun_b),
    .rx_done_tick(done_b)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (c == 0);
      c = (c + 1) % 4;
    end
  end

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    logic       ov;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe,
                              input logic bk, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bk = bk; e.ov = ov;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: each rx_done_tick pops one expected word, checked one clk later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_a) begin
        pulses_a++;
        @(negedge clk);
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse_a: dout 0x%0h with nothing expected", dout_a);
        end else begin
          e = q_a.pop_front();
          chk("frame_a {dout,pe,fe,bk,ov,valid}",
              32'({dout_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_valid_a}),
              32'({e.d[7:0], e.pe, e.fe, e.bk, e.ov, 1'b1}));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_b) begin
        pulses_b++;
        @(negedge clk);
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse_b: dout 0x%0h with nothing expected", dout_b);
        end else begin
          e = q_b.pop_front();
          chk("frame_b {dout,pe,fe,bk,ov,valid}",
              32'({dout_b, parity_err_b, frame_err_b, break_det_b, overrun_b, rx_valid_b}),
              32'({e.d[6:0], e.pe, e.fe, e.bk, e.ov, 1'b1}));
        end
      end
    end
  end

  task automatic set_rx(input int w, input logic b);
    if (w == 0) rx_a = b;
    else        rx_b = b;
  endtask

  task automatic bit_wait();
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                            input bit has_par, input logic par, input logic stp);
    set_rx(w, 1'b1);
    repeat (BT / 2) @(posedge clk);
    #1;
    set_rx(w, 1'b0);
    bit_wait();
    for (int i = 0; i < nb; i++) begin
      set_rx(w, d[i]);
      bit_wait();
    end
    if (has_par) begin
      set_rx(w, par);
      bit_wait();
    end
    set_rx(w, stp);
    bit_wait();
    set_rx(w, 1'b1);
  endtask

  task automatic ack(input int w);
    @(negedge clk);
    if (w == 0) rd_ack_a = 1'b1;
    else        rd_ack_b = 1'b1;
    @(posedge clk);
    #1;
    rd_ack_a = 1'b0;
    rd_ack_b = 1'b0;
  endtask

  task automatic ack_at_done(input int w);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if ((w == 0) ? done_a : done_b) begin
        if (w == 0) rd_ack_a = 1'b1;
        else        rd_ack_b = 1'b1;
        @(posedge clk);
        #1;
        rd_ack_a = 1'b0;
        rd_ack_b = 1'b0;
        got = 1'b1;
      end
    end
    chk("ack_at_done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 32'({rx_valid_a, dout_a, parity_err_a, frame_err_a, break_det_a, overrun_a, done_a}), 32'd0);
    chk("reset_b", 32'({rx_valid_b, dout_b, parity_err_b, frame_err_b, break_det_b, overrun_b, done_b}), 32'd0);
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 8N1 frame 0xA5
    q_a.push_back(mk(9'h0A5, 0, 0, 0, 0));
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_valid", 32'(rx_valid_a), 32'd1);
    chk("t1_one_pulse", pulses_a, 1);
    ack(0);
    @(negedge clk);
    chk("t1_ack_clears_valid", 32'(rx_valid_a), 32'd0);
    chk("t1_dout_kept", 32'(dout_a), 32'h0A5);

    // false start: low for 5 ticks only
    p = pulses_a;
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (3 * BT) @(posedge clk);
    @(negedge clk);
    chk("t2_no_pulse", pulses_a, p);
    chk("t2_valid_low", 32'(rx_valid_a), 32'd0);

    // overrun
    q_a.push_back(mk(9'h011, 0, 0, 0, 0));
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    q_a.push_back(mk(9'h011, 0, 0, 0, 1));
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_overrun_dout", 32'({dout_a, overrun_a}), 32'({8'h11, 1'b1}));
    ack(0);
    @(negedge clk);
    chk("t4_ack_clears", 32'({rx_valid_a, overrun_a}), 32'd0);
    q_a.push_back(mk(9'h033, 0, 0, 0, 0));
    send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b1);
    q_a.push_back(mk(9'h033, 0, 0, 0, 1));
    send_frame(0, 9'h044, 8, 1'b0, 1'b0, 1'b1);
    q_a.push_back(mk(9'h022, 0, 0, 0, 0));
    fork
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
      ack_at_done(0);
    join
    ack(0);
    @(negedge clk);
    chk("t4_final_ack", 32'({rx_valid_a, overrun_a, dout_a}), 32'({1'b0, 1'b0, 8'h22}));

    // break: low for 3 frame times
    p = pulses_a;
    q_a.push_back(mk(9'h000, 0, 1, 1, 0));
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (30 * BT) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (2 * BT) @(posedge clk);
    @(negedge clk);
    chk("t5_single_break_pulse", pulses_a, p + 1);
    ack(0);
    q_a.push_back(mk(9'h05A, 0, 0, 0, 0));
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);

    // 7E1 on instance B
    q_b.push_back(mk(9'h041, 1, 0, 0, 0));
    send_frame(1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
    ack(1);
    q_b.push_back(mk(9'h041, 0, 0, 0, 0));
    send_frame(1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
    ack(1);
    q_b.push_back(mk(9'h043, 0, 0, 0, 0));
    send_frame(1, 9'h043, 7, 1'b1, 1'b1, 1'b1);
    q_b.push_back(mk(9'h043, 0, 0, 0, 1));
    send_frame(1, 9'h043, 7, 1'b1, 1'b0, 1'b1);

    // async reset in the middle of DATA; 0x5A still held on A
    @(negedge clk);
    chk("t6_pre_valid", 32'(rx_valid_a), 32'd1);
    @(posedge clk);
    #1 rx_a = 1'b0;
    bit_wait();
    rx_a = 1'b1; bit_wait();
    rx_a = 1'b1; bit_wait();
    rx_a = 1'b0;
    repeat (BT / 2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_reset_a", 32'({rx_valid_a, dout_a, parity_err_a, frame_err_a, break_det_a, overrun_a, done_a}), 32'd0);
    chk("t6_async_reset_b", 32'({rx_valid_b, dout_b, parity_err_b, overrun_b}), 32'd0);
    rx_a = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2 * BT) @(posedge clk);
    #1;
    q_a.push_back(mk(9'h0C3, 0, 0, 0, 0));
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1);

    repeat (2 * BT) @(posedge clk);
    @(negedge clk);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
